data_slow_to_fast_rx: RTL and testbench

Single-clock receiver that moves samples from the slow (codec, 12 MHz) domain into the fast (DSP, 100 MHz) domain, the return path opposite the fast-to-slow sample transfer. The slow side presents a held data word plus a level valid flag. This block synchronizes the flag into `Clk_Fast`, detects its rising edge, and captures the word. It buffers captured words in a small first-word-fall-through FIFO and hands them to the DSP over a valid/ready handshake, with overflow accounting.

---
 rtl/fast_slow_pkg.sv | 16 +
 rtl/sync_fwft_fifo.sv | 65 ++++++
 rtl/data_slow_to_fast_rx.sv | 104 ++++++++++
 tb/tb_data_slow_to_fast_rx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fast_slow_pkg.sv
// rtl/fast_slow_pkg.sv - shared types and constants for the slow/fast sample paths
//
// Purpose : drop-counter sizing, default sample type and a saturating
//           increment helper used by the sample transfer blocks.
package fast_slow_pkg;

  localparam int                  DROP_CNT_W   = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'd255;

  typedef logic [15:0] sample_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] i_val);
    return (i_val == DROP_CNT_MAX) ? i_val : i_val + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// rtl/sync_fwft_fifo.sv - single-clock first-word-fall-through FIFO
//
// Purpose : small register-array FIFO; the head word is visible on o_data
//           whenever o_empty is low.
// Ports   : i_clk/i_rst  clock and synchronous active-high reset
//           i_push/i_data write request and word
//           i_pop        consume head word (ignored while empty)
//           o_data       head word
//           o_full/o_empty/o_level occupancy
module sync_fwft_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_level == (PTR_W+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      // Storage is cleared so stale words can never surface after a reset.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/data_slow_to_fast_rx.sv
// rtl/data_slow_to_fast_rx.sv - slow-to-fast sample receiver with FWFT buffer
//
// Purpose : synchronizes the slow-domain valid level into Clk_Fast, captures
//           Data_In_Slow on each rising edge of it, buffers samples and hands
//           them out over valid/ready with sticky overflow accounting.
// Ports   : Clk_Fast/Rst             clock, synchronous active-high reset
//           Data_In_Slow/Valid_In_Slow held word and level flag from slow side
//           Data_Out_Fast/Valid_Out_Fast/Ready_In_Fast  output handshake
//           Fill_Level               words stored
//           Overflow/Drop_Count/Clear_Overflow  drop accounting
module data_slow_to_fast_rx
  import fast_slow_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          Clk_Fast,
  input  logic                          Rst,
  input  logic [WIDTH-1:0]              Data_In_Slow,
  input  logic                          Valid_In_Slow,
  output logic [WIDTH-1:0]              Data_Out_Fast,
  output logic                          Valid_Out_Fast,
  input  logic                          Ready_In_Fast,
  output logic [$clog2(FIFO_DEPTH):0]   Fill_Level,
  output logic                          Overflow,
  output logic [DROP_CNT_W-1:0]         Drop_Count,
  input  logic                          Clear_Overflow
);

  localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic [ARM_W-1:0]       r_arm_cnt;
  logic                   r_overflow;
  logic [DROP_CNT_W-1:0]  r_drop_cnt;

  logic w_sync_out;
  logic w_armed;
  logic w_rise;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;
  logic w_push;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_armed    = (r_arm_cnt == ARM_DONE);

  // sync_prev always follows the chain, so a level already high when the arm
  // window closes is seen as "old" and never produces a rise.
  always_ff @(posedge Clk_Fast) begin
    if (Rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
      r_arm_cnt   <= '0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], Valid_In_Slow};
      r_sync_prev <= w_sync_out;
      if (!w_armed) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  assign w_rise = w_armed & w_sync_out & ~r_sync_prev;
  assign w_pop  = Valid_Out_Fast & Ready_In_Fast;
  assign w_drop = w_rise & w_full & ~w_pop;
  assign w_push = w_rise & ~w_drop;

  // A drop in the same cycle as a clear wins and restarts the count at one.
  always_ff @(posedge Clk_Fast) begin
    if (Rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= Clear_Overflow ? DROP_CNT_W'(1) : sat_inc(r_drop_cnt);
    end else if (Clear_Overflow) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  sync_fwft_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (Clk_Fast),
    .i_rst   (Rst),
    .i_push  (w_push),
    .i_data  (Data_In_Slow),
    .i_pop   (w_pop),
    .o_data  (Data_Out_Fast),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (Fill_Level)
  );

  assign Valid_Out_Fast = ~w_empty;
  assign Overflow       = r_overflow;
  assign Drop_Count     = r_drop_cnt;

endmodule

// File: tb/tb_data_slow_to_fast_rx.sv
// tb/tb_data_slow_to_fast_rx.sv - directed vector bench for data_slow_to_fast_rx
module tb_data_slow_to_fast_rx;
  import fast_slow_pkg::*;

  logic          Clk_Fast;
  logic          Rst;
  sample_t       Data_In_Slow;
  logic          Valid_In_Slow;
  sample_t       Data_Out_Fast;
  logic          Valid_Out_Fast;
  logic          Ready_In_Fast;
  logic [2:0]    Fill_Level;
  logic          Overflow;
  logic [7:0]    Drop_Count;
  logic          Clear_Overflow;

  int n_vec = 0;
  int n_err = 0;

  data_slow_to_fast_rx #(
    .WIDTH       (16),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk_Fast       (Clk_Fast),
    .Rst            (Rst),
    .Data_In_Slow   (Data_In_Slow),
    .Valid_In_Slow  (Valid_In_Slow),
    .Data_Out_Fast  (Data_Out_Fast),
    .Valid_Out_Fast (Valid_Out_Fast),
    .Ready_In_Fast  (Ready_In_Fast),
    .Fill_Level     (Fill_Level),
    .Overflow       (Overflow),
    .Drop_Count     (Drop_Count),
    .Clear_Overflow (Clear_Overflow)
  );

  initial Clk_Fast = 1'b0;
  always #5 Clk_Fast = ~Clk_Fast;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic [2:0]  el;
    logic        eo;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge Clk_Fast);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Low phase first so data is settled before the flag rises.
  task automatic send(input logic [15:0] d, input int hi, input int lo);
    Data_In_Slow  = d;
    Valid_In_Slow = 1'b0;
    repeat (lo) step();
    Valid_In_Slow = 1'b1;
    repeat (hi) step();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    step();
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Data_In_Slow = '0; Valid_In_Slow = 1'b0;
    Ready_In_Fast = 1'b0; Clear_Overflow = 1'b0;
    step();
    step();
    chk("rst_valid", Valid_Out_Fast, 0);
    chk("rst_level", Fill_Level, 0);
    chk("rst_data", Data_Out_Fast, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_cnt", Drop_Count, 0);
    Rst = 1'b0;
    repeat (5) step();

    // Single sample, latency 2, then drained; second sample with ready held high.
    tbl[0]  = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b1, 16'hA5A5, 3'd1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b1, 16'h1234, 3'd1, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};
    tbl[11] = '{1'b0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0, 8'd0};

    for (int i = 0; i < 12; i++) begin
      Valid_In_Slow  = tbl[i].v;
      Data_In_Slow   = tbl[i].d;
      Ready_In_Fast  = tbl[i].rdy;
      Clear_Overflow = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_valid", i), Valid_Out_Fast, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), Data_Out_Fast, tbl[i].ed);
      chk($sformatf("tbl%0d_level", i), Fill_Level, tbl[i].el);
      chk($sformatf("tbl%0d_ovf", i), Overflow, tbl[i].eo);
      chk($sformatf("tbl%0d_cnt", i), Drop_Count, tbl[i].ec);
    end
    Ready_In_Fast = 1'b0;
    Clear_Overflow = 1'b0;

    // Burst of six without drain: four stored, two dropped.
    for (int i = 1; i <= 6; i++) send(16'(i), 4, 4);
    chk("burst_level", Fill_Level, 4);
    chk("burst_ovf", Overflow, 1);
    chk("burst_cnt", Drop_Count, 2);
    Valid_In_Slow = 1'b0;
    Ready_In_Fast = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("burst_drain%0d_valid", i), Valid_Out_Fast, 1);
      chk($sformatf("burst_drain%0d_data", i), Data_Out_Fast, i);
      step();
    end
    chk("burst_empty_valid", Valid_Out_Fast, 0);
    chk("burst_empty_level", Fill_Level, 0);
    Ready_In_Fast = 1'b0;
    Clear_Overflow = 1'b1;
    step();
    Clear_Overflow = 1'b0;
    chk("clr_ovf", Overflow, 0);
    chk("clr_cnt", Drop_Count, 0);

    // Push while full with a pop in the rise cycle: no drop.
    for (int i = 0; i < 4; i++) send(16'h0010 + 16'(i), 4, 4);
    chk("full_level", Fill_Level, 4);
    Data_In_Slow = 16'h0014;
    Valid_In_Slow = 1'b0;
    repeat (4) step();
    Valid_In_Slow = 1'b1;
    step();
    step();
    Ready_In_Fast = 1'b1;
    step();
    Ready_In_Fast = 1'b0;
    chk("pp_level", Fill_Level, 4);
    chk("pp_ovf", Overflow, 0);
    chk("pp_cnt", Drop_Count, 0);
    chk("pp_head", Data_Out_Fast, 16'h0011);
    step();
    Valid_In_Slow = 1'b0;
    Ready_In_Fast = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("pp_drain%0d", i), Data_Out_Fast, 16'h0010 + i);
      step();
    end
    chk("pp_empty", Valid_Out_Fast, 0);
    Ready_In_Fast = 1'b0;

    // Flag high across reset release: no capture until a fresh edge.
    Valid_In_Slow = 1'b1;
    Data_In_Slow = 16'h0055;
    do_reset();
    repeat (10) step();
    chk("hi_rst_valid", Valid_Out_Fast, 0);
    chk("hi_rst_level", Fill_Level, 0);
    send(16'h0077, 4, 4);
    chk("hi_rst_one_level", Fill_Level, 1);
    chk("hi_rst_one_data", Data_Out_Fast, 16'h0077);
    Valid_In_Slow = 1'b0;
    repeat (4) step();
    chk("hi_rst_still_one", Fill_Level, 1);

    // Saturation of the drop counter, then clear/drop collision.
    do_reset();
    repeat (4) step();
    for (int i = 0; i < 304; i++) send(16'(i), 3, 3);
    chk("sat_level", Fill_Level, 4);
    chk("sat_ovf", Overflow, 1);
    chk("sat_cnt", Drop_Count, 255);
    chk("sat_head", Data_Out_Fast, 16'h0000);
    Data_In_Slow = 16'hBEEF;
    Valid_In_Slow = 1'b0;
    repeat (3) step();
    Valid_In_Slow = 1'b1;
    step();
    step();
    Clear_Overflow = 1'b1;
    step();
    Clear_Overflow = 1'b0;
    chk("coll_ovf", Overflow, 1);
    chk("coll_cnt", Drop_Count, 1);
    step();
    Valid_In_Slow = 1'b0;
    Clear_Overflow = 1'b1;
    step();
    Clear_Overflow = 1'b0;
    chk("clr2_ovf", Overflow, 0);
    chk("clr2_cnt", Drop_Count, 0);

    // Reset with three words stored: contents discarded.
    do_reset();
    repeat (4) step();
    for (int i = 1; i <= 3; i++) send(16'h0030 + 16'(i), 3, 3);
    chk("mid_level3", Fill_Level, 3);
    Valid_In_Slow = 1'b0;
    do_reset();
    chk("mid_rst_valid", Valid_Out_Fast, 0);
    chk("mid_rst_level", Fill_Level, 0);
    chk("mid_rst_data", Data_Out_Fast, 0);
    repeat (4) step();
    send(16'h0044, 4, 4);
    chk("mid_new_level", Fill_Level, 1);
    chk("mid_new_data", Data_Out_Fast, 16'h0044);
    Ready_In_Fast = 1'b1;
    step();
    Ready_In_Fast = 1'b0;
    chk("mid_after_valid", Valid_Out_Fast, 0);
    chk("mid_after_data", Data_Out_Fast, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
